// File: rtl/ct_fadd_issue_arb_if.sv
// Purpose : handshake and status bundle between the FADD requesters and the issue arbiter.
// Latency : none, wires only.
// Backpress: gnt is the only backpressure; a requester holds vld/long/tag until it sees gnt.
//
// Port summary
//   req0_* / req1_*   : op request (vld, long, tag) and combinational grant
//   flush_vld/src     : per-source kill of in-flight ops
//   ex1_* / ex2_/ex3_ : stage select and pipedown strobes towards the datapath
//   wb_*              : shared writeback port
//   arb_busy          : any stage or writeback valid
//   perf_*            : counter clear and the two performance counters
interface ct_fadd_issue_arb_if #(
   parameter int TAG_W     = 7,
   parameter int CNT_WIDTH = 16
);
   logic                 req0_vld;
   logic                 req0_long;
   logic [TAG_W-1:0]     req0_tag;
   logic                 req0_gnt;
   logic                 req1_vld;
   logic                 req1_long;
   logic [TAG_W-1:0]     req1_tag;
   logic                 req1_gnt;
   logic                 flush_vld;
   logic                 flush_src;
   logic [1:0]           ex1_pipe_sel;
   logic                 ex1_src;
   logic [TAG_W-1:0]     ex1_tag;
   logic                 ex2_pipedown;
   logic                 ex3_pipedown;
   logic                 wb_vld;
   logic                 wb_src;
   logic [TAG_W-1:0]     wb_tag;
   logic                 arb_busy;
   logic                 perf_clr;
   logic [CNT_WIDTH-1:0] perf_gnt_cnt;
   logic [CNT_WIDTH-1:0] perf_conflict_cnt;

   // Requester / pipe-control side
   modport master (
      output req0_vld, req0_long, req0_tag,
      output req1_vld, req1_long, req1_tag,
      output flush_vld, flush_src, perf_clr,
      input  req0_gnt, req1_gnt,
      input  ex1_pipe_sel, ex1_src, ex1_tag, ex2_pipedown, ex3_pipedown,
      input  wb_vld, wb_src, wb_tag, arb_busy,
      input  perf_gnt_cnt, perf_conflict_cnt
   );

   // Arbiter side
   modport slave (
      input  req0_vld, req0_long, req0_tag,
      input  req1_vld, req1_long, req1_tag,
      input  flush_vld, flush_src, perf_clr,
      output req0_gnt, req1_gnt,
      output ex1_pipe_sel, ex1_src, ex1_tag, ex2_pipedown, ex3_pipedown,
      output wb_vld, wb_src, wb_tag, arb_busy,
      output perf_gnt_cnt, perf_conflict_cnt
   );
endinterface

// File: rtl/ct_fadd_issue_arb.sv
// Purpose : round-robin issue arbiter and EX1/EX2/EX3/WB sequencer for the shared FADD pipe.
// Latency : grant at t -> EX1 at t+1; short op wb at t+2; long op EX2 t+2, EX3 t+3, wb t+4.
// Backpress: the pipe never stalls; a short op is held off (no gnt) while a live long op sits in EX2.
//
// Ports
//   forever_cpuclk : clock
//   cpurst         : asynchronous reset, active-high
//   fadd_if        : ct_fadd_issue_arb_if.slave (requests, grants, flush, stage strobes, wb, perf)
// Optional feature: define FADD_ARB_PERF_CNT_EN to build the saturating grant / conflict counters;
// without it both counter outputs are tied to 0 and perf_clr is ignored.
module ct_fadd_issue_arb #(
   parameter int TAG_W     = 7,
   parameter int CNT_WIDTH = 16
) (
   input logic                 forever_cpuclk,
   input logic                 cpurst,
   ct_fadd_issue_arb_if.slave  fadd_if
);

   logic [1:0]       ex1_pipe_sel;
   logic             ex1_src;
   logic [TAG_W-1:0] ex1_tag;
   logic             ex2_vld;
   logic             ex2_src;
   logic [TAG_W-1:0] ex2_tag;
   logic             ex3_vld;
   logic             ex3_src;
   logic [TAG_W-1:0] ex3_tag;
   logic             wb_vld;
   logic             wb_src;
   logic [TAG_W-1:0] wb_tag;
   logic             rr_last_src;   // source granted most recently

   logic             flush0;
   logic             flush1;
   logic             ex1_kill;
   logic             ex2_kill;
   logic             ex3_kill;
   logic             ex2_live;
   logic             req0_elig;
   logic             req1_elig;
   logic             gnt0;
   logic             gnt1;
   logic             gnt_any;
   logic             gnt_long;
   logic [TAG_W-1:0] gnt_tag;
   logic             wb_from_ex1;
   logic             wb_from_ex3;

   assign flush0   = fadd_if.flush_vld & ~fadd_if.flush_src;
   assign flush1   = fadd_if.flush_vld &  fadd_if.flush_src;
   assign ex1_kill = fadd_if.flush_vld & (fadd_if.flush_src == ex1_src);
   assign ex2_kill = fadd_if.flush_vld & (fadd_if.flush_src == ex2_src);
   assign ex3_kill = fadd_if.flush_vld & (fadd_if.flush_src == ex3_src);

   // A long op in EX2 now owns the writeback slot two cycles out, which is exactly
   // where a short op granted now would land. Flushing that op releases the slot at once.
   assign ex2_live = ex2_vld & ~ex2_kill;

   assign req0_elig = fadd_if.req0_vld & ~flush0 & ~(~fadd_if.req0_long & ex2_live);
   assign req1_elig = fadd_if.req1_vld & ~flush1 & ~(~fadd_if.req1_long & ex2_live);

   // On a tie the source not granted last wins.
   assign gnt0 = req0_elig & (~req1_elig |  rr_last_src);
   assign gnt1 = req1_elig & (~req0_elig | ~rr_last_src);

   assign gnt_any  = gnt0 | gnt1;
   assign gnt_long = gnt1 ? fadd_if.req1_long : fadd_if.req0_long;
   assign gnt_tag  = gnt1 ? fadd_if.req1_tag  : fadd_if.req0_tag;

   // Short ops retire out of EX1, long ops out of EX3; eligibility guarantees these
   // two never fire in the same cycle.
   assign wb_from_ex1 = ex1_pipe_sel[0] & ~ex1_kill;
   assign wb_from_ex3 = ex3_vld & ~ex3_kill;

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         ex1_pipe_sel <= 2'b00;
         ex1_src      <= 1'b0;
         ex1_tag      <= '0;
         ex2_vld      <= 1'b0;
         ex2_src      <= 1'b0;
         ex2_tag      <= '0;
         ex3_vld      <= 1'b0;
         ex3_src      <= 1'b0;
         ex3_tag      <= '0;
         wb_vld       <= 1'b0;
         wb_src       <= 1'b0;
         wb_tag       <= '0;
         rr_last_src  <= 1'b1;
      end else begin
         ex1_pipe_sel <= {gnt_any & gnt_long, gnt_any & ~gnt_long};
         if (gnt_any) begin
            ex1_src     <= gnt1;
            ex1_tag     <= gnt_tag;
            rr_last_src <= gnt1;
         end

         ex2_vld <= ex1_pipe_sel[1] & ~ex1_kill;
         if (ex1_pipe_sel[1]) begin
            ex2_src <= ex1_src;
            ex2_tag <= ex1_tag;
         end

         ex3_vld <= ex2_vld & ~ex2_kill;
         if (ex2_vld) begin
            ex3_src <= ex2_src;
            ex3_tag <= ex2_tag;
         end

         wb_vld <= wb_from_ex1 | wb_from_ex3;
         if (wb_from_ex3) begin
            wb_src <= ex3_src;
            wb_tag <= ex3_tag;
         end else if (wb_from_ex1) begin
            wb_src <= ex1_src;
            wb_tag <= ex1_tag;
         end
      end
   end

   assign fadd_if.req0_gnt     = gnt0;
   assign fadd_if.req1_gnt     = gnt1;
   assign fadd_if.ex1_pipe_sel = ex1_pipe_sel;
   assign fadd_if.ex1_src      = ex1_src;
   assign fadd_if.ex1_tag      = ex1_tag;
   assign fadd_if.ex2_pipedown = ex2_vld;
   assign fadd_if.ex3_pipedown = ex3_vld;
   assign fadd_if.wb_vld       = wb_vld;
   assign fadd_if.wb_src       = wb_src;
   assign fadd_if.wb_tag       = wb_tag;
   assign fadd_if.arb_busy     = (|ex1_pipe_sel) | ex2_vld | ex3_vld | wb_vld;

`ifdef FADD_ARB_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] gnt_cnt;
   logic [CNT_WIDTH-1:0] conflict_cnt;
   logic                 conflict_evt;

   // A short request that would otherwise be eligible but is held off by the EX2 long op.
   assign conflict_evt = (fadd_if.req0_vld & ~fadd_if.req0_long & ex2_live & ~flush0) |
                         (fadd_if.req1_vld & ~fadd_if.req1_long & ex2_live & ~flush1);

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         gnt_cnt      <= '0;
         conflict_cnt <= '0;
      end else if (fadd_if.perf_clr) begin
         gnt_cnt      <= '0;
         conflict_cnt <= '0;
      end else begin
         if (gnt_any && !(&gnt_cnt)) begin
            gnt_cnt <= gnt_cnt + CNT_WIDTH'(1);
         end
         if (conflict_evt && !(&conflict_cnt)) begin
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign fadd_if.perf_gnt_cnt      = gnt_cnt;
   assign fadd_if.perf_conflict_cnt = conflict_cnt;
`else
   assign fadd_if.perf_gnt_cnt      = '0;
   assign fadd_if.perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_ct_fadd_issue_arb.sv
// Purpose : random-stimulus bench for ct_fadd_issue_arb against an op-age reference model.
// Latency : outputs compared every cycle on the falling edge, grants 1ns after inputs settle.
// Backpress: requesters hold each op until granted; flushes and counter clears are random.
module tb_ct_fadd_issue_arb;

   localparam int TAG_W   = 7;
   localparam int CW      = 2;
   localparam int NCYC    = 900;
   localparam int RST_CYC = 450;
   localparam int SAT     = (1 << CW) - 1;

   logic forever_cpuclk = 1'b0;
   logic cpurst         = 1'b1;

   always #5 forever_cpuclk = ~forever_cpuclk;

   ct_fadd_issue_arb_if #(.TAG_W(TAG_W), .CNT_WIDTH(CW)) fif ();

   ct_fadd_issue_arb #(.TAG_W(TAG_W), .CNT_WIDTH(CW)) dut (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .fadd_if        (fif)
   );

   // Each in-flight op is tracked by its age: age 1 = EX1; a short op writes back at
   // age 2, a long op is in EX2 at age 2, EX3 at age 3 and writes back at age 4.
   typedef struct {
      bit             src;
      bit             lng;
      logic [TAG_W-1:0] tag;
      int             age;
   } op_t;

   op_t              ops[$];
   int               n_vec = 0;
   int               n_err = 0;
   bit               m_last;
   logic             m_wb_src;
   logic [TAG_W-1:0] m_wb_tag;
   int               m_gcnt;
   int               m_ccnt;

   bit               p[2];
   bit               l[2];
   logic [TAG_W-1:0] t[2];
   bit               fv;
   bit               fs;
   bit               pclr;
   bit               force_tie;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [1:0]       sel = 2'b00;
      bit               e2 = 0;
      bit               e3 = 0;
      bit               wbv = 0;
      bit               e1_src = 0;
      logic [TAG_W-1:0] e1_tag = '0;
      foreach (ops[i]) begin
         if (ops[i].age == 1) begin
            sel    = ops[i].lng ? 2'b10 : 2'b01;
            e1_src = ops[i].src;
            e1_tag = ops[i].tag;
         end
         if (ops[i].lng && ops[i].age == 2) e2 = 1;
         if (ops[i].lng && ops[i].age == 3) e3 = 1;
         if ((!ops[i].lng && ops[i].age == 2) || (ops[i].lng && ops[i].age == 4)) begin
            wbv      = 1;
            m_wb_src = ops[i].src;
            m_wb_tag = ops[i].tag;
         end
      end
      chk("ex1_pipe_sel", 32'(fif.ex1_pipe_sel), 32'(sel));
      if (sel != 2'b00) begin
         chk("ex1_src", 32'(fif.ex1_src), 32'(e1_src));
         chk("ex1_tag", 32'(fif.ex1_tag), 32'(e1_tag));
      end
      chk("ex2_pipedown", 32'(fif.ex2_pipedown), 32'(e2));
      chk("ex3_pipedown", 32'(fif.ex3_pipedown), 32'(e3));
      chk("wb_vld", 32'(fif.wb_vld), 32'(wbv));
      chk("wb_src", 32'(fif.wb_src), 32'(m_wb_src));
      chk("wb_tag", 32'(fif.wb_tag), 32'(m_wb_tag));
      chk("arb_busy", 32'(fif.arb_busy), 32'(ops.size() != 0));
`ifdef FADD_ARB_PERF_CNT_EN
      chk("perf_gnt_cnt", 32'(fif.perf_gnt_cnt), 32'(m_gcnt));
      chk("perf_conflict_cnt", 32'(fif.perf_conflict_cnt), 32'(m_ccnt));
`else
      chk("perf_gnt_cnt", 32'(fif.perf_gnt_cnt), 32'd0);
      chk("perf_conflict_cnt", 32'(fif.perf_conflict_cnt), 32'd0);
`endif
   endtask

   // Evaluate this cycle's grants from the model state and driven inputs, then age the pipe.
   task automatic model_step(output bit g0, output bit g1);
      bit  ex2_live = 0;
      bit  e0, e1, conflict;
      op_t nq[$];
      op_t o;
      foreach (ops[i])
         if (ops[i].lng && ops[i].age == 2 && !(fv && fs == ops[i].src)) ex2_live = 1;
      e0 = p[0] && !(fv && fs == 1'b0) && !(!l[0] && ex2_live);
      e1 = p[1] && !(fv && fs == 1'b1) && !(!l[1] && ex2_live);
      g0 = e0 && (!e1 || m_last == 1'b1);
      g1 = e1 && (!e0 || m_last == 1'b0);
      chk("req0_gnt", 32'(fif.req0_gnt), 32'(g0));
      chk("req1_gnt", 32'(fif.req1_gnt), 32'(g1));

      conflict = (p[0] && !l[0] && ex2_live && !(fv && fs == 1'b0)) ||
                 (p[1] && !l[1] && ex2_live && !(fv && fs == 1'b1));
      if (pclr) begin
         m_gcnt = 0;
         m_ccnt = 0;
      end else begin
         if ((g0 || g1) && m_gcnt < SAT) m_gcnt++;
         if (conflict && m_ccnt < SAT) m_ccnt++;
      end

      foreach (ops[i]) begin
         o = ops[i];
         if ((!o.lng && o.age == 2) || (o.lng && o.age == 4)) continue;
         if (fv && fs == o.src) continue;
         o.age++;
         nq.push_back(o);
      end
      if (g0 || g1) begin
         o.src = g1;
         o.lng = g1 ? l[1] : l[0];
         o.tag = g1 ? t[1] : t[0];
         o.age = 1;
         nq.push_back(o);
         m_last = g1;
      end
      ops = nq;
      if (g0) p[0] = 0;
      if (g1) p[1] = 0;
   endtask

   task automatic model_reset();
      ops.delete();
      m_last   = 1'b1;
      m_wb_src = 1'b0;
      m_wb_tag = '0;
      m_gcnt   = 0;
      m_ccnt   = 0;
      p[0]     = 0;
      p[1]     = 0;
   endtask

   task automatic drive();
      fif.req0_vld  = p[0];
      fif.req0_long = l[0];
      fif.req0_tag  = t[0];
      fif.req1_vld  = p[1];
      fif.req1_long = l[1];
      fif.req1_tag  = t[1];
      fif.flush_vld = fv;
      fif.flush_src = fs;
      fif.perf_clr  = pclr;
   endtask

   initial begin
      bit g0, g1;
      model_reset();
      l[0] = 0; l[1] = 0; t[0] = '0; t[1] = '0;
      fv = 0; fs = 0; pclr = 0; force_tie = 0;
      drive();
      repeat (2) @(negedge forever_cpuclk);
      check_outputs();
      chk("rst_ex1_tag", 32'(fif.ex1_tag), 32'd0);
      cpurst = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge forever_cpuclk);
         check_outputs();

         if (cyc == RST_CYC) begin
            cpurst = 1'b1;
            model_reset();
            fv = 0; pclr = 0;
            drive();
            #1;
            chk("rst_ex1_pipe_sel", 32'(fif.ex1_pipe_sel), 32'd0);
            chk("rst_ex2_pipedown", 32'(fif.ex2_pipedown), 32'd0);
            chk("rst_ex3_pipedown", 32'(fif.ex3_pipedown), 32'd0);
            chk("rst_wb_vld", 32'(fif.wb_vld), 32'd0);
            chk("rst_arb_busy", 32'(fif.arb_busy), 32'd0);
            chk("rst_wb_tag", 32'(fif.wb_tag), 32'd0);
            chk("rst_ex1_tag", 32'(fif.ex1_tag), 32'd0);
            chk("rst_perf_gnt_cnt", 32'(fif.perf_gnt_cnt), 32'd0);
            @(posedge forever_cpuclk);
            #1;
            cpurst    = 1'b0;
            force_tie = 1;
            continue;
         end

         // Requester stimulus: directed opening, then random ops held until granted.
         for (int i = 0; i < 2; i++) begin
            if (!p[i]) begin
               if (cyc == 0) begin
                  p[i] = (i == 0);
                  l[i] = 1;
                  t[i] = 7'd5;
               end else if (cyc < 8) begin
                  p[i] = 0;
               end else if (cyc < 12 || force_tie) begin
                  p[i] = 1;
                  l[i] = 0;
                  t[i] = TAG_W'($urandom);
               end else if ($urandom_range(0, 9) < 6) begin
                  p[i] = 1;
                  l[i] = 1'($urandom_range(0, 1));
                  t[i] = TAG_W'($urandom);
               end
            end
         end
         fv   = (cyc >= 20) && !force_tie && ($urandom_range(0, 7) == 0);
         fs   = 1'($urandom_range(0, 1));
         pclr = (cyc >= 20) && ($urandom_range(0, 15) == 0);
         drive();
         #1;
         model_step(g0, g1);
         if (force_tie) begin
            chk("tie_after_rst", 32'(fif.req0_gnt), 32'd1);
            force_tie = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ct_fadd_issue_arb.md
Name: ct_fadd_issue_arb

Overview:
- Issue arbiter and stage sequencer for the shared FADD datapath.
- Two requesters issue into one pipe:
  - long ops (3-stage add/sub) travel EX1→EX2→EX3;
  - short ops (compare/sign-inject/move) finish in EX1.
- Both op classes share one writeback port.
- The block drives the EX1 select and the EX2/EX3 pipedowns, resolves writeback-slot conflicts, arbitrates round-robin and handles per-source flush.

Parameters:
TAG_W, 7, width of the instruction tag carried alongside each op
CNT_WIDTH, 16, width of the performance counters

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  asynchronous reset, active-high
req0_vld  in  1  requester 0 has an op
req0_long  in  1  1 = long op, 0 = short op
req0_tag  in  TAG_W  requester 0 tag
req0_gnt  out  1  requester 0 granted this cycle (combinational)
req1_vld  in  1  requester 1 has an op
req1_long  in  1  1 = long op, 0 = short op
req1_tag  in  TAG_W  requester 1 tag
req1_gnt  out  1  requester 1 granted this cycle (combinational)
flush_vld  in  1  kill in-flight ops of one source
flush_src  in  1  source to kill (0 = requester 0, 1 = requester 1)
ex1_pipe_sel  out  2  one-hot EX1 select: bit1 = long, bit0 = short
ex1_src  out  1  source of the op in EX1
ex1_tag  out  TAG_W  tag of the op in EX1
ex2_pipedown  out  1  long op valid in EX2
ex3_pipedown  out  1  long op valid in EX3
wb_vld  out  1  writeback valid
wb_src  out  1  writeback source
wb_tag  out  TAG_W  writeback tag
arb_busy  out  1  any stage valid or wb_vld
perf_clr  in  1  clear the performance counters
perf_gnt_cnt  out  CNT_WIDTH  grant count
perf_conflict_cnt  out  CNT_WIDTH  writeback-conflict stall count

Behaviour:
- Reset (asynchronous, cpurst=1):
  - all stage valids and wb_vld = 0;
  - tag and src registers = 0;
  - round-robin pointer = 1, so requester 0 wins the first tie;
  - counters = 0.
- Timing, for a grant in cycle t:
  - the op occupies EX1 in t+1 (ex1_pipe_sel, ex1_src and ex1_tag are registered);
  - short op: wb_vld in t+2;
  - long op: ex2_pipedown in t+2, ex3_pipedown in t+3, wb_vld in t+4.
- Grant rules:
  - at most one grant per cycle;
  - gnt implies vld; the requester holds vld, long and tag stable until it sees gnt.
- Eligibility of requester i:
  - req_i_vld;
  - AND NOT (flush_vld and flush_src==i);
  - AND NOT (req_i_long==0 and ex2_live).
- ex2_live = ex2_pipedown AND NOT (flush_vld and flush_src == EX2 source).
  - A short op granted at t would collide at t+2 with the long op in EX2 at t.
  - Long/long and short/short never collide.
- Arbitration:
  - one eligible requester: it is granted;
  - both eligible: grant the one not granted last;
  - the pointer updates only on a grant.
- Flush:
  - flush_vld with flush_src=s, in the same cycle, clears propagation of every EX1/EX2/EX3 entry whose src==s;
  - no wb_vld is produced from the flushed entries;
  - current-cycle outputs are unaffected;
  - a wb_vld already being driven is not recalled;
  - a flushed EX2 entry frees its writeback slot in the same cycle.
- Stage advance:
  - the pipe never stalls; every stage advances each cycle;
  - stages with no input become invalid.
- wb_src and wb_tag are held when wb_vld=0.

Optional Feature:
- Macro FADD_ARB_PERF_CNT_EN defined:
  - perf_gnt_cnt increments on any grant;
  - perf_conflict_cnt increments in any cycle where a short request is vld but blocked only by ex2_live;
  - both counters saturate at all-ones;
  - perf_clr zeroes both synchronously and has priority over increment.
- Macro absent: the counter logic is not built; both outputs are tied to 0 and perf_clr is ignored.

Test Plan:
- Reset released, req0 long tag 5 at t → ex1_pipe_sel=2'b10 at t+1, ex2_pipedown at t+2, ex3_pipedown at t+3, wb_vld with wb_tag=5, wb_src=0 at t+4; arb_busy high t+1..t+4.
- req0 and req1 both short and valid every cycle for 4 cycles → grants alternate 0,1,0,1; four consecutive wb_vld at t+2..t+5 with alternating wb_src.
- req0 long at t, req1 short held from t+2 → req1_gnt=0 at t+2 (perf_conflict_cnt=1 with macro), granted at t+3; wb for req0 at t+4, req1 at t+5, no overlap.
- Long op from source 1 in EX2 at t with flush_vld=1, flush_src=1 at t → no ex3_pipedown at t+1, no wb_vld at t+2; a req0 short presented at t is granted at t.
- cpurst asserted while long ops occupy EX2 and EX3 → all pipedowns and wb_vld drop immediately; the first tie after release is granted to req0.
- With FADD_ARB_PERF_CNT_EN and CNT_WIDTH=2, 5 grants → perf_gnt_cnt saturates at 3; perf_clr → 0 next cycle; without the macro both counters read 0 throughout.
